// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared constants, expect_type encodings, error codes and FSM states for the USB receive path
package usb_rx_pkg;
  localparam int DATA_BITS = 80;
  localparam int HSHAKE_BITS = 16;
  localparam int TIMEOUT = 255;
  localparam logic [7:0] SYNC_PAT = 8'b0000_0001;
  typedef enum logic [1:0] {EXP_NONE = 2'b00, EXP_HSHAKE = 2'b10, EXP_DATA = 2'b11} expect_e;
  typedef enum logic [2:0] {ERR_OK, ERR_PID, ERR_CRC, ERR_LEN, ERR_TIMEOUT} pkt_err_e;
  typedef enum logic [2:0] {S_IDLE, S_HUNT, S_RECV, S_STREAM, S_DRAIN, S_REPORT} state_e;
endpackage

// File: rtl/rx_pkt_ctrl_sync_hunter.sv
// sync_hunter: 8-bit valid-qualified shift register that flags SYNC_PAT on the bit completing it
// Ports: clk/rst_n (async active-low), clr empties the register, bit_valid/bit_in shift one bit
//   (first-arrived bit ends up in bit 0), match is combinational on the value being shifted in.
module sync_hunter
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic bit_valid,
  input  logic bit_in,
  output logic match
);
  logic [7:0] sr, sr_n;
  assign sr_n = {bit_in, sr[7:1]};
  assign match = bit_valid && !clr && sr_n == SYNC_PAT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else sr <= clr ? '0 : bit_valid ? sr_n : sr;
endmodule

// File: rtl/rx_pkt_ctrl.sv
// rx_pkt_ctrl: USB receive sequencer - SYNC hunt, body buffering, gapless replay to decoder, per-packet status
// Ports: clk, rst_n (async active-low); rx_arm/expect_type arm one packet; rx_bit_valid/rx_bit/rx_eop from the
//   unstuffer; start_decode/end_decode/dec_bit form the burst into the decoder; PID_error in, rc_PIDerror ack out;
//   crc_done/crc_ok from the CRC checker; pkt_done/pkt_err status strobe; busy outside IDLE.
// Macro RX_STATS_EN adds stat_good/stat_bad, saturating counts of OK and failed packets.
module rx_pkt_ctrl
  import usb_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_arm,
  input  logic [1:0]  expect_type,
  input  logic        rx_bit_valid,
  input  logic        rx_bit,
  input  logic        rx_eop,
  output logic        start_decode,
  output logic        end_decode,
  output logic        dec_bit,
  input  logic        PID_error,
  output logic        rc_PIDerror,
  input  logic        crc_done,
  input  logic        crc_ok,
  output logic        pkt_done,
  output logic [2:0]  pkt_err,
`ifdef RX_STATS_EN
  output logic [15:0] stat_good,
  output logic [15:0] stat_bad,
`endif
  output logic        busy
);
  state_e state;
  logic [6:0] len, cnt, cnt_n;
  logic [7:0] tmo;
  logic [DATA_BITS-1:0] pkt_buf;
  logic pid_seen, crc_seen, crc_good, settle, hunt_match, tmo_hit;
  assign cnt_n = cnt + 7'(rx_bit_valid);
  assign tmo_hit = tmo == 8'(TIMEOUT - 1);
  assign busy = state != S_IDLE;
  sync_hunter u_hunt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state != S_HUNT),
    .bit_valid(rx_bit_valid),
    .bit_in   (rx_bit),
    .match    (hunt_match)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      len <= '0;
      cnt <= '0;
      tmo <= '0;
      pkt_buf <= '0;
      pid_seen <= 1'b0;
      crc_seen <= 1'b0;
      crc_good <= 1'b0;
      settle <= 1'b0;
      start_decode <= 1'b0;
      end_decode <= 1'b0;
      dec_bit <= 1'b0;
      rc_PIDerror <= 1'b0;
      pkt_done <= 1'b0;
      pkt_err <= '0;
    end else begin
      start_decode <= 1'b0;
      end_decode <= 1'b0;
      dec_bit <= 1'b0;
      rc_PIDerror <= 1'b0;
      pkt_done <= 1'b0;
      pkt_err <= '0;
      case (state)
        S_IDLE:
          if (rx_arm && (expect_type == EXP_HSHAKE || expect_type == EXP_DATA)) begin
            len <= expect_type == EXP_DATA ? 7'(DATA_BITS) : 7'(HSHAKE_BITS);
            tmo <= '0;
            state <= S_HUNT;
          end
        S_HUNT:
          if (rx_eop) begin
            state <= S_REPORT;
            pkt_done <= 1'b1;
            pkt_err <= ERR_LEN;
          end else if (hunt_match) begin
            cnt <= '0;
            state <= S_RECV;
          end else if (tmo_hit) begin
            state <= S_REPORT;
            pkt_done <= 1'b1;
            pkt_err <= ERR_TIMEOUT;
          end else tmo <= tmo + 8'd1;
        S_RECV:
          // a bit landing on a full buffer is overlength; otherwise store first, then judge EOP on the new count
          if (rx_bit_valid && cnt == len) begin
            state <= S_REPORT;
            pkt_done <= 1'b1;
            pkt_err <= ERR_LEN;
          end else begin
            if (rx_bit_valid) pkt_buf[cnt] <= rx_bit;
            cnt <= cnt_n;
            if (rx_eop && cnt_n == len) begin
              start_decode <= 1'b1;
              dec_bit <= pkt_buf[0];
              cnt <= 7'd1;
              state <= S_STREAM;
            end else if (rx_eop) begin
              state <= S_REPORT;
              pkt_done <= 1'b1;
              pkt_err <= ERR_LEN;
            end
          end
        S_STREAM:
          if (cnt == len) begin
            end_decode <= 1'b1;
            tmo <= '0;
            pid_seen <= 1'b0;
            crc_seen <= 1'b0;
            crc_good <= 1'b0;
            settle <= 1'b0;
            state <= S_DRAIN;
          end else begin
            dec_bit <= pkt_buf[cnt];
            cnt <= cnt + 7'd1;
          end
        S_DRAIN: begin
          // PID_error is a level; acknowledge only its first sighting
          if (PID_error && !pid_seen) begin
            pid_seen <= 1'b1;
            rc_PIDerror <= 1'b1;
          end
          // after crc_done, linger two cycles so a late PID verdict still wins
          if (crc_seen) begin
            settle <= 1'b1;
            if (settle) begin
              state <= S_REPORT;
              pkt_done <= 1'b1;
              pkt_err <= (pid_seen || PID_error) ? ERR_PID : crc_good ? ERR_OK : ERR_CRC;
            end
          end else if (crc_done) begin
            crc_seen <= 1'b1;
            crc_good <= crc_ok;
          end else if (tmo_hit) begin
            state <= S_REPORT;
            pkt_done <= 1'b1;
            pkt_err <= ERR_TIMEOUT;
          end else tmo <= tmo + 8'd1;
        end
        S_REPORT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
`ifdef RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_good <= '0;
      stat_bad <= '0;
    end else if (pkt_done) begin
      if (pkt_err == 3'(ERR_OK) && stat_good != '1) stat_good <= stat_good + 16'd1;
      if (pkt_err != 3'(ERR_OK) && stat_bad != '1) stat_bad <= stat_bad + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// tb_rx_pkt_ctrl: directed scoreboard bench for rx_pkt_ctrl
module tb_rx_pkt_ctrl;
  localparam logic [1:0] HS = 2'b10;
  localparam logic [1:0] DT = 2'b11;
  localparam logic [7:0] SYNC = 8'b0000_0001;
  logic clk = 1'b0, rst_n = 1'b0;
  logic rx_arm = 1'b0, rx_bit_valid = 1'b0, rx_bit = 1'b0, rx_eop = 1'b0;
  logic [1:0] expect_type = 2'b00;
  logic PID_error = 1'b0, crc_done = 1'b0, crc_ok = 1'b0;
  logic start_decode, end_decode, dec_bit, rc_PIDerror, pkt_done, busy;
  logic [2:0] pkt_err;
`ifdef RX_STATS_EN
  logic [15:0] stat_good, stat_bad;
`endif
  int n_cmp = 0, n_bad = 0;
  int start_cnt = 0, rc_cnt = 0, done_cnt = 0, burst_cyc = 0, exp_burst = 0;
  logic in_burst = 1'b0;
  logic exp_bits[$];
  logic [2:0] exp_err[$];

  rx_pkt_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rx_arm(rx_arm), .expect_type(expect_type),
    .rx_bit_valid(rx_bit_valid), .rx_bit(rx_bit), .rx_eop(rx_eop),
    .start_decode(start_decode), .end_decode(end_decode), .dec_bit(dec_bit),
    .PID_error(PID_error), .rc_PIDerror(rc_PIDerror), .crc_done(crc_done), .crc_ok(crc_ok),
    .pkt_done(pkt_done), .pkt_err(pkt_err),
`ifdef RX_STATS_EN
    .stat_good(stat_good), .stat_bad(stat_bad),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (start_decode) begin
      start_cnt++;
      burst_cyc = 0;
      in_burst = 1'b1;
    end
    if (rc_PIDerror) rc_cnt++;
    if (in_burst) begin
      burst_cyc++;
      if (end_decode) begin
        chk("burst_len", burst_cyc, exp_burst);
        chk("end_bit", dec_bit, 0);
        chk("bits_left", exp_bits.size(), 0);
        in_burst = 1'b0;
      end else begin
        chk("bit_avail", exp_bits.size() != 0, 1);
        if (exp_bits.size() != 0) chk("dec_bit", dec_bit, exp_bits.pop_front());
      end
    end
    if (pkt_done) begin
      done_cnt++;
      chk("err_avail", exp_err.size() != 0, 1);
      if (exp_err.size() != 0) chk("pkt_err", pkt_err, exp_err.pop_front());
    end
  end

  task automatic arm(input logic [1:0] et);
    expect_type = et;
    rx_arm = 1'b1;
    @(negedge clk);
    rx_arm = 1'b0;
    expect_type = 2'b00;
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) @(negedge clk);
    rx_bit_valid = 1'b1;
    rx_bit = b;
    @(negedge clk);
    rx_bit_valid = 1'b0;
    rx_bit = 1'b0;
  endtask

  task automatic send_sync();
    logic [7:0] p = SYNC;
    for (int i = 0; i < 8; i++) send_bit(p[i], int'($urandom_range(0, 2)));
  endtask

  task automatic send_eop();
    rx_eop = 1'b1;
    @(negedge clk);
    rx_eop = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!end_decode && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_end_decode", end_decode, 1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!pkt_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pkt_done", pkt_done, 1);
    @(negedge clk);
  endtask

  task automatic run_pkt(input logic [1:0] et, input logic [79:0] body, input int nbits,
                         input logic ok, input logic pid);
    arm(et);
    for (int i = 0; i < nbits; i++) exp_bits.push_back(body[i]);
    exp_burst = nbits + 1;
    exp_err.push_back(pid ? 3'd1 : ok ? 3'd0 : 3'd2);
    send_sync();
    for (int i = 0; i < nbits; i++) send_bit(body[i], int'($urandom_range(0, 3)));
    send_eop();
    wait_end(nbits + 10);
    @(negedge clk);
    crc_done = 1'b1;
    crc_ok = ok;
    PID_error = pid;
    @(negedge clk);
    crc_done = 1'b0;
    crc_ok = 1'b0;
    @(negedge clk);
    PID_error = 1'b0;
    wait_done(20);
  endtask

  initial begin
    int s0, r0, d0, n;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {start_decode, end_decode, dec_bit, rc_PIDerror, pkt_done, pkt_err, busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    arm(2'b00);
    chk("arm_none_ignored", busy, 0);

    r0 = rc_cnt;
    s0 = start_cnt;
    arm(HS);
    chk("arm_busy", busy, 1);
    exp_bits.push_back(1'b0);
    repeat (2) @(negedge clk);
    exp_bits.delete();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_pkt(HS, {64'd0, 8'h2D, 8'hD2}, 16, 1'b1, 1'b0);
    chk("hs_one_burst", start_cnt - s0, 1);
    chk("hs_no_rc", rc_cnt - r0, 0);
    chk("hs_idle_after", busy, 0);

    r0 = rc_cnt;
    run_pkt(DT, {$urandom, $urandom, 16'($urandom)}, 80, 1'b0, 1'b0);
    chk("data_crc_no_rc", rc_cnt - r0, 0);

    r0 = rc_cnt;
    run_pkt(HS, {64'd0, 16'($urandom)}, 16, 1'b1, 1'b1);
    chk("pid_rc_once", rc_cnt - r0, 1);

    s0 = start_cnt;
    arm(DT);
    send_sync();
    for (int i = 0; i < 79; i++) send_bit(1'($urandom), int'($urandom_range(0, 1)));
    exp_err.push_back(3'd3);
    send_eop();
    wait_done(4);
    chk("short_no_start", start_cnt - s0, 0);

    arm(DT);
    send_sync();
    for (int i = 0; i < 80; i++) send_bit(1'($urandom), int'($urandom_range(0, 1)));
    exp_err.push_back(3'd3);
    send_bit(1'b1, 0);
    chk("long_done_on_bit81", pkt_done, 1);
    wait_done(4);
    chk("long_no_start", start_cnt - s0, 0);

    exp_err.push_back(3'd4);
    arm(HS);
    n = 0;
    while (!pkt_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("hunt_timeout_window", n >= 250 && n <= 260, 1);
    @(negedge clk);
    chk("timeout_idle", busy, 0);

    d0 = done_cnt;
    arm(DT);
    send_sync();
    for (int i = 0; i < 20; i++) send_bit(1'($urandom), 0);
    chk("recv_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {start_decode, end_decode, dec_bit, rc_PIDerror, pkt_done, pkt_err, busy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_idle", busy, 0);

    for (int k = 0; k < 3; k++) run_pkt(HS, {64'd0, 16'($urandom)}, 16, 1'b1, 1'b0);
    run_pkt(HS, {64'd0, 16'($urandom)}, 16, 1'b0, 1'b0);
    arm(HS);
    send_sync();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 0);
    exp_err.push_back(3'd3);
    send_eop();
    wait_done(4);
`ifdef RX_STATS_EN
    chk("stat_good", stat_good, 3);
    chk("stat_bad", stat_bad, 2);
`endif
    chk("scoreboard_bits_empty", exp_bits.size(), 0);
    chk("scoreboard_err_empty", exp_err.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
